// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding and the
// poison word loaded when a data-memory access times out.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEADBEEF_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout_counter.sv
// WAIT-cycle watchdog: reloads while clear is high, counts down while enabled,
// and flags the cycle in which the TIMEOUT-th enabled cycle is reached.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic clrn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign expired = enable && (count == 8'd0);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while an
// access is outstanding, and retires misaligned or timed-out accesses safely.
//
// state | meaning
// IDLE  | pass-through; aligned memop issues request, misaligned retires as bubble
// WAIT  | request held stable until ack or watchdog expiry
// DONE  | load data presented for one cycle, pipeline released
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        exe_wreg,
    input  logic        exe_m2reg,
    input  logic        exe_wmem,
    input  logic [31:0] exe_alu,
    input  logic [31:0] exe_b,
    input  logic [4:0]  exe_rn,
    input  logic        exe_branch,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        mem_stall,
    output logic        mem_wreg,
    output logic        mem_m2reg,
    output logic        mem_branch,
    output logic [31:0] mem_mo,
    output logic [31:0] mem_alu,
    output logic [4:0]  mem_rn,
    output logic        mem_err
);

    state_t      state, state_nxt;
    logic [31:0] load_data;
    logic        memop, aligned, expired;
    logic        capture, timed_out, misaligned;

    assign memop      = exe_m2reg | exe_wmem;
    assign aligned    = (exe_alu[1:0] == 2'b00);
    assign misaligned = (state == ST_IDLE) && memop && !aligned;
    assign capture    = dmem_ack && (((state == ST_IDLE) && memop && aligned) || (state == ST_WAIT));
    assign timed_out  = (state == ST_WAIT) && !dmem_ack && expired;

    mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .clrn    (clrn),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (memop && aligned) state_nxt = dmem_ack ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem_ack || expired) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem_req   = 1'b0;
        mem_stall  = 1'b0;
        mem_wreg   = exe_wreg;
        mem_m2reg  = exe_m2reg;
        mem_branch = exe_branch;
        mem_mo     = 32'd0;
        case (state)
            ST_IDLE: begin
                if (memop && aligned) begin
                    dmem_req  = 1'b1;
                    mem_stall = 1'b1;
                end else if (memop) begin
                    mem_wreg  = 1'b0;
                    mem_m2reg = 1'b0;
                end
            end
            ST_WAIT: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
            end
            ST_DONE: mem_mo = load_data;
            default: ;
        endcase
        // Reset must silence the bus even while a memop sits on exe_*.
        if (!clrn) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
        end
        if (mem_stall) begin
            mem_wreg   = 1'b0;
            mem_branch = 1'b0;
        end
    end

    assign dmem_we    = dmem_req & exe_wmem;
    assign dmem_addr  = dmem_req ? {exe_alu[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = dmem_req ? exe_b : 32'd0;
    assign mem_alu    = exe_alu;
    assign mem_rn     = exe_rn;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            load_data <= 32'd0;
            mem_err   <= 1'b0;
        end else begin
            if (misaligned) mem_err <= 1'b1;
            if (capture) begin
                load_data <= dmem_rdata;
            end else if (timed_out) begin
                load_data <= DEADBEEF_WORD;
                mem_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level model:
// each instruction is an access with a chosen ack cycle, expanded into stall/done cycles.
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = 1000;

    logic        clk = 1'b0;
    logic        clrn;
    logic        exe_wreg, exe_m2reg, exe_wmem, exe_branch;
    logic [31:0] exe_alu, exe_b;
    logic [4:0]  exe_rn;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        mem_wreg, mem_m2reg, mem_branch, mem_err;
    logic [31:0] mem_mo, mem_alu;
    logic [4:0]  mem_rn;

    int n_chk  = 0;
    int n_pass = 0;
    logic exp_err;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .exe_wreg   (exe_wreg),
        .exe_m2reg  (exe_m2reg),
        .exe_wmem   (exe_wmem),
        .exe_alu    (exe_alu),
        .exe_b      (exe_b),
        .exe_rn     (exe_rn),
        .exe_branch (exe_branch),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .mem_stall  (mem_stall),
        .mem_wreg   (mem_wreg),
        .mem_m2reg  (mem_m2reg),
        .mem_branch (mem_branch),
        .mem_mo     (mem_mo),
        .mem_alu    (mem_alu),
        .mem_rn     (mem_rn),
        .mem_err    (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Outputs expected in any cycle where no request is outstanding.
    task automatic chk_quiet(input string tag, input logic [31:0] exp_mo,
                             input logic exp_wreg, input logic exp_m2reg);
        chk({tag, ".stall"}, 32'(mem_stall), 32'd0);
        chk({tag, ".req"},   32'(dmem_req),  32'd0);
        chk({tag, ".we"},    32'(dmem_we),   32'd0);
        chk({tag, ".addr"},  dmem_addr,      32'd0);
        chk({tag, ".wdata"}, dmem_wdata,     32'd0);
        chk({tag, ".mo"},    mem_mo,         exp_mo);
        chk({tag, ".wreg"},  32'(mem_wreg),  32'(exp_wreg));
        chk({tag, ".m2reg"}, 32'(mem_m2reg), 32'(exp_m2reg));
        chk({tag, ".br"},    32'(mem_branch), 32'(exe_branch));
        chk({tag, ".alu"},   mem_alu,        exe_alu);
        chk({tag, ".rn"},    32'(mem_rn),    32'(exe_rn));
        chk({tag, ".err"},   32'(mem_err),   32'(exp_err));
    endtask

    // ack_at: stall-cycle index (0 = issue cycle) at which memory acks; >TIMEOUT means never.
    task automatic do_instr(input string tag, input logic wreg, input logic m2reg, input logic wmem,
                            input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                            input logic br, input int ack_at, input logic [31:0] rd);
        logic        memop;
        logic [31:0] exp_mo;
        memop = m2reg | wmem;
        exe_wreg = wreg; exe_m2reg = m2reg; exe_wmem = wmem;
        exe_alu = alu; exe_b = b; exe_rn = rn; exe_branch = br;
        if (!memop || alu[1:0] != 2'b00) begin
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            @(negedge clk);
            chk_quiet(tag, 32'd0, memop ? 1'b0 : wreg, memop ? 1'b0 : m2reg);
            @(posedge clk); #1;
            if (memop) exp_err = 1'b1;
        end else begin
            exp_mo = 32'hDEAD_BEEF;
            for (int k = 0; k <= TIMEOUT; k++) begin
                dmem_ack   = (k == ack_at);
                dmem_rdata = (k == ack_at) ? rd : $urandom;
                @(negedge clk);
                chk({tag, ".s_stall"}, 32'(mem_stall),  32'd1);
                chk({tag, ".s_req"},   32'(dmem_req),   32'd1);
                chk({tag, ".s_we"},    32'(dmem_we),    32'(wmem));
                chk({tag, ".s_addr"},  dmem_addr,       {alu[31:2], 2'b00});
                chk({tag, ".s_wdata"}, dmem_wdata,      b);
                chk({tag, ".s_wreg"},  32'(mem_wreg),   32'd0);
                chk({tag, ".s_br"},    32'(mem_branch), 32'd0);
                chk({tag, ".s_err"},   32'(mem_err),    32'(exp_err));
                @(posedge clk); #1;
                if (k == ack_at) begin
                    exp_mo = rd;
                    break;
                end
                if (k == TIMEOUT) exp_err = 1'b1;
            end
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            @(negedge clk);
            chk_quiet({tag, ".done"}, exp_mo, wreg, m2reg);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clrn = 1'b0; exp_err = 1'b0;
        exe_wreg = 1'b0; exe_m2reg = 1'b0; exe_wmem = 1'b0; exe_branch = 1'b0;
        exe_alu = 32'd0; exe_b = 32'd0; exe_rn = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        #12;
        chk_quiet("reset", 32'd0, 1'b0, 1'b0);
        @(negedge clk); clrn = 1'b1;
        @(posedge clk); #1;

        do_instr("alu_op",     1'b1, 1'b0, 1'b0, 32'h10,  32'h5, 5'd3, 1'b0, 0, 32'd0);
        do_instr("branch",     1'b0, 1'b0, 1'b0, 32'h80,  32'h0, 5'd0, 1'b1, 0, 32'd0);
        do_instr("load_0w",    1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 1'b0, 0, 32'h1234_5678);
        do_instr("store_3c",   1'b1, 1'b0, 1'b1, 32'h44,  32'hCAFE_F00D, 5'd7, 1'b1, 2, 32'h0BAD_0BAD);
        do_instr("ld_st_both", 1'b1, 1'b1, 1'b1, 32'h48,  32'h1111_2222, 5'd8, 1'b0, 1, 32'h7777_8888);
        do_instr("ack_last",   1'b1, 1'b1, 1'b0, 32'h4C,  32'h0, 5'd9, 1'b0, TIMEOUT, 32'h5A5A_A5A5);
        chk("no_err_yet", 32'(mem_err), 32'd0);
        do_instr("misalign",   1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4, 1'b0, 0, 32'd0);
        chk("misalign_err", 32'(mem_err), 32'd1);

        // Reset during the second WAIT cycle of a pending load.
        exe_wreg = 1'b1; exe_m2reg = 1'b1; exe_wmem = 1'b0; exe_alu = 32'h300; exe_rn = 5'd2;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_stall", 32'(mem_stall), 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("rst_req",   32'(dmem_req),  32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_err",   32'(mem_err),   32'd0);
        exp_err = 1'b0;
        @(negedge clk); clrn = 1'b1;
        exe_m2reg = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        do_instr("late_ack",   1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 5'd2, 1'b0, 0, 32'd0);
        do_instr("post_rst",   1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 5'd2, 1'b0, 0, 32'hABCD_0123);

        do_instr("timeout",    1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd6, 1'b0, NO_ACK, 32'd0);
        chk("timeout_err", 32'(mem_err), 32'd1);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            int          ack_at;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            ack_at = ($urandom_range(0, 9) == 0) ? NO_ACK : int'($urandom_range(0, 5));
            do_instr("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), ack_at, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
